// File: rtl/neuron_pe.sv
// neuron_pe: multi-lane saturating MAC neuron engine.
// Lanes are snapshotted on the last term and drained one lane per cycle to a LUT.
module neuron_pe #(
    parameter int N_LANES   = 4,
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 11,
    parameter int GUARD_W   = 4,
    parameter int ADDR_FRAC = 7,
    parameter int SAT_INT   = 15,
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                        pi_clk,
    input  logic                        pi_rst,
    input  logic                        pi_valid,
    input  logic                        pi_last,
    input  logic                        pi_clc_accumulator,
    input  logic [DATA_W-1:0]           pi_inputs,
    input  logic [N_LANES*DATA_W-1:0]   pi_weights,
    input  logic [N_LANES*DATA_W-1:0]   pi_bias,
    output logic                        po_ready,
    output logic                        po_BRAM_en,
    output logic [DATA_W-1:0]           po_BRAM_add,
    output logic [LW-1:0]               po_lane,
    output logic                        po_last_lane,
    output logic                        po_sat,
    output logic                        po_overrun
);

    localparam int ACC_W   = 2*DATA_W + GUARD_W;
    localparam int SHIFT   = 2*FRAC_W - ADDR_FRAC;
    localparam int SAT_MAG = SAT_INT*(2**ADDR_FRAC) + (2**ADDR_FRAC) - 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(N_LANES-1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t                    r_state;
    logic [LW-1:0]             r_lane_idx;
    logic signed [ACC_W-1:0]   r_acc  [N_LANES];
    logic signed [ACC_W-1:0]   r_snap [N_LANES];
    logic                      r_en;
    logic [DATA_W-1:0]         r_add;
    logic [LW-1:0]             r_lane;
    logic                      r_last_lane;
    logic                      r_sat;
    logic                      r_overrun;

    logic signed [2*DATA_W-1:0] w_prod    [N_LANES];
    logic signed [ACC_W-1:0]    w_mac_sum [N_LANES];
    logic [N_LANES-1:0]         w_mac_sat;
    logic                       w_any_mac_sat;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_mac_en;
    logic signed [ACC_W-1:0]    w_snap_sel;
    logic [DATA_W-1:0]          w_bias_sel;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_sum;
    logic                       w_pp_sat;
    logic [ACC_W-1:0]           w_abs;
    logic [ACC_W-1:0]           w_mag_full;
    logic [DATA_W-2:0]          w_mag;
    logic [DATA_W-1:0]          w_addr;

    // Returns {overflow, clamped sum} of two ACC_W signed values.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        else
            sat_add = {1'b0, s[ACC_W-1:0]};
    endfunction

    assign w_ready  = (r_state == S_IDLE) ||
                      (r_state == S_DRAIN && r_lane_idx == LAST_IDX);
    assign w_mac_en = pi_valid && !pi_clc_accumulator;
    assign w_accept = w_mac_en && pi_last && w_ready;

    always_comb begin
        w_any_mac_sat = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            w_prod[i] = $signed(pi_inputs) *
                        $signed(pi_weights[i*DATA_W +: DATA_W]);
            {w_mac_sat[i], w_mac_sum[i]} = sat_add(r_acc[i], ACC_W'(w_prod[i]));
            w_any_mac_sat = w_any_mac_sat | w_mac_sat[i];
        end
    end

    always_comb begin
        w_snap_sel = r_snap[r_lane_idx];
        w_bias_sel = pi_bias[r_lane_idx*DATA_W +: DATA_W];
        w_bias_ext = ACC_W'($signed(w_bias_sel)) <<< FRAC_W;
        {w_pp_sat, w_sum} = sat_add(w_snap_sel, w_bias_ext);
        w_abs      = w_sum[ACC_W-1] ? ACC_W'(-w_sum) : ACC_W'(w_sum);
        w_mag_full = w_abs >> SHIFT;
        w_mag      = (w_mag_full > ACC_W'(SAT_MAG)) ?
                     (DATA_W-1)'(SAT_MAG) : w_mag_full[DATA_W-2:0];
        // No negative zero: sign only survives a non-zero magnitude.
        w_addr     = {w_sum[ACC_W-1] && (w_mag != '0), w_mag};
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            r_state     <= S_IDLE;
            r_lane_idx  <= '0;
            r_en        <= 1'b0;
            r_add       <= '0;
            r_lane      <= '0;
            r_last_lane <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            if (pi_clc_accumulator) begin
                for (int i = 0; i < N_LANES; i++)
                    r_acc[i] <= '0;
            end else if (pi_valid) begin
                for (int i = 0; i < N_LANES; i++) begin
                    if (w_accept) begin
                        r_snap[i] <= w_mac_sum[i];
                        r_acc[i]  <= '0;
                    end else begin
                        r_acc[i]  <= w_mac_sum[i];
                    end
                end
            end

            if (w_mac_en && pi_last && !w_ready)
                r_overrun <= 1'b1;

            if ((w_mac_en && w_any_mac_sat) ||
                (r_state == S_DRAIN && w_pp_sat))
                r_sat <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    r_en <= 1'b0;
                    if (w_accept) begin
                        r_state    <= S_DRAIN;
                        r_lane_idx <= '0;
                    end
                end
                S_DRAIN: begin
                    r_en        <= 1'b1;
                    r_add       <= w_addr;
                    r_lane      <= r_lane_idx;
                    r_last_lane <= (r_lane_idx == LAST_IDX);
                    if (r_lane_idx == LAST_IDX) begin
                        r_state    <= w_accept ? S_DRAIN : S_IDLE;
                        r_lane_idx <= '0;
                    end else begin
                        r_lane_idx <= r_lane_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign po_ready     = w_ready;
    assign po_BRAM_en   = r_en;
    assign po_BRAM_add  = r_add;
    assign po_lane      = r_lane;
    assign po_last_lane = r_last_lane;
    assign po_sat       = r_sat;
    assign po_overrun   = r_overrun;

endmodule
